// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared types and widths for the latch bank controller.
// Holds the write FSM state enum, data/key widths and a one-hot helper.
package latch_bank_pkg;

  localparam int LAT_W = 4;
  localparam int KEY_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  function automatic logic [1:0] onehot2(
    input logic idx
  );
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/latch_bank_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter for the latch bank controller.
// Ports: clk, rst (sync, high), req[1:0], take (grant accepted),
//        gnt_idx (winning requester), gnt_any (some request pending).
import latch_bank_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_idx,
  output logic       gnt_any
);

  // Index of the last requester served; reset to 1 so 0 wins first.
  logic last;

  assign gnt_any = |req;

  always_comb begin
    gnt_idx = 1'b0;
    unique case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (take && gnt_any) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: arbitrated writer for a 4-bit latch bank, with
// setup/strobe/hold timing and an optional key lock.
// Optional lock: define LATCH_BANK_CTRL_LOCK_EN to build the key logic.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[1:0]          level write requests, held until ack
//   wdata0, wdata1    write data of requester 0 / 1
//   ack[1:0]          one-cycle completion pulse to granted requester
//   err[1:0]          one-cycle reject pulse while locked
//   lat_d, lat_le     latch bank data and enable
//   key_valid, key    key presentation strobe and value
//   unlocked, lockout key accepted / permanent lockout
//   shadow_q          copy of last value written to the bank
import latch_bank_pkg::*;

module latch_bank_ctrl #(
  parameter int               PULSE_W  = 2,
  parameter int               HOLD_W   = 1,
  parameter logic [KEY_W-1:0] KEY      = 8'hA5,
  parameter int               MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LAT_W-1:0] wdata0,
  input  logic [LAT_W-1:0] wdata1,
  output logic [1:0]       ack,
  output logic [1:0]       err,
  output logic [LAT_W-1:0] lat_d,
  output logic             lat_le,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key,
  output logic             unlocked,
  output logic             lockout,
  output logic [LAT_W-1:0] shadow_q
);

  localparam logic [3:0] PW_M1 = 4'(PULSE_W - 1);
  localparam logic [3:0] HW_M1 = 4'(HOLD_W - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       gidx;
  logic       arb_idx;
  logic       arb_any;
  logic       take;

  // Arbiter pointer only advances when IDLE actually issues a grant.
  assign take = (state == IDLE) && unlocked;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .take    (take),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

`ifdef LATCH_BANK_CTRL_LOCK_EN
  localparam int FW = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);

  logic [FW-1:0] fails;
  logic          unl_q;
  logic          lock_q;
  logic [1:0]    err_q;

  assign unlocked = unl_q;
  assign lockout  = lock_q;
  assign err      = err_q;

  // Once lockout is set no key is evaluated until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fails  <= '0;
      unl_q  <= 1'b0;
      lock_q <= 1'b0;
    end else if (key_valid && !unl_q && !lock_q) begin
      if (key == KEY) begin
        unl_q <= 1'b1;
      end else begin
        if (fails != FMAX) begin
          fails <= fails + 1'b1;
        end
        if (fails >= FMAX - 1'b1) begin
          lock_q <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_key;

  assign unused_key = ^{key_valid, key};
  assign unlocked   = 1'b1;
  assign lockout    = 1'b0;
  assign err        = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gidx     <= 1'b0;
      lat_d    <= '0;
      lat_le   <= 1'b0;
      ack      <= 2'b00;
      shadow_q <= '0;
`ifdef LATCH_BANK_CTRL_LOCK_EN
      err_q    <= 2'b00;
`endif
    end else begin
      ack <= 2'b00;
`ifdef LATCH_BANK_CTRL_LOCK_EN
      err_q <= 2'b00;
`endif
      unique case (state)
        IDLE: begin
          if (arb_any && unlocked) begin
            gidx  <= arb_idx;
            lat_d <= arb_idx ? wdata1 : wdata0;
            state <= SETUP;
          end
`ifdef LATCH_BANK_CTRL_LOCK_EN
          else if (arb_any) begin
            err_q <= req;
          end
`endif
        end
        SETUP: begin
          lat_le <= 1'b1;
          cnt    <= PW_M1;
          state  <= STROBE;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            lat_le <= 1'b0;
            cnt    <= HW_M1;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            ack      <= onehot2(gidx);
            shadow_q <= lat_d;
            state    <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: directed scoreboard bench for latch_bank_ctrl.
// Key-lock scenarios run only when LATCH_BANK_CTRL_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_latch_bank_ctrl;
  import latch_bank_pkg::*;

  localparam int PW = 2;
  localparam int HW = 1;
  localparam int LAT = 1 + PW + HW + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] wdata0, wdata1;
  logic       key_valid;
  logic [7:0] key;
  logic [1:0] ack, err;
  logic [3:0] lat_d, shadow_q;
  logic       lat_le, unlocked, lockout;

  latch_bank_ctrl #(
    .PULSE_W  (PW),
    .HOLD_W   (HW),
    .KEY      (8'hA5),
    .MAX_FAIL (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .err       (err),
    .lat_d     (lat_d),
    .lat_le    (lat_le),
    .key_valid (key_valid),
    .key       (key),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .shadow_q  (shadow_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [1:0] v;
    logic [3:0] sh;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nfail = 0;
  bit   err_seen = 1'b0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per ack/err pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (err != 2'b00) err_seen = 1'b1;
      if (!rst && (ack != 2'b00 || err != 2'b00)) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {28'd0, ack, err}, 32'd0);
        end else begin
          e = q.pop_front();
          if (e.is_err) begin
            chk("err", {30'd0, err}, {30'd0, e.v});
            chk("err_no_ack", {30'd0, ack}, 32'd0);
          end else begin
            chk("ack", {30'd0, ack}, {30'd0, e.v});
            chk("shadow", {28'd0, shadow_q}, {28'd0, e.sh});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_ack(input int r, input logic [3:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.v      = (r == 1) ? 2'b10 : 2'b01;
    e.sh     = d;
    q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] v);
    exp_t e;
    e.is_err = 1'b1;
    e.v      = v;
    e.sh     = 4'h0;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    key_valid = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] k);
    key = k;
    key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
  endtask

  // Raise req[r], hold until ack[r]; reports latency and strobe length.
  task automatic wr(input int r, input logic [3:0] d, input bit push,
                    output int lat, output int le, output bit dbad);
    if (push) push_ack(r, d);
    if (r == 1) wdata1 = d;
    else wdata0 = d;
    req[r] = 1'b1;
    lat = 0;
    le = 0;
    dbad = 1'b0;
    while (lat < 40) begin
      tick(1);
      lat++;
      if (lat_le) le++;
      if (lat_d !== d) dbad = 1'b1;
      if (ack[r]) break;
    end
    req[r] = 1'b0;
    if (!ack[r]) chk("ack_timeout", lat, 0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    int  lat, le, cnt;
    bit  dbad;
    req = 2'b00;
    wdata0 = 4'h0;
    wdata1 = 4'h0;
    key = 8'h00;
    key_valid = 1'b0;
    rst = 1'b1;
    do_reset();

    chk("rst_lat_le", lat_le, 0);
    chk("rst_lat_d", lat_d, 0);
    chk("rst_shadow", shadow_q, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_lockout", lockout, 0);
`ifdef LATCH_BANK_CTRL_LOCK_EN
    chk("rst_unlocked", unlocked, 0);

    // Locked request is rejected with err and no strobe.
    push_err(2'b10);
    req = 2'b10;
    le = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      req = 2'b00;
      if (lat_le) le++;
    end
    chk("locked_le", le, 0);
    send_key(8'hA5);
    chk("unlock", unlocked, 1);
    wr(1, 4'h5, 1'b1, lat, le, dbad);
    chk("post_unlock_lat", lat, LAT);
    do_reset();
    send_key(8'hA5);
`else
    chk("rst_unlocked", unlocked, 1);
`endif

    // Single write: timing of strobe, data and ack.
    wr(0, 4'h9, 1'b1, lat, le, dbad);
    chk("w9_latency", lat, LAT);
    chk("w9_le_cycles", le, PW);
    chk("w9_lat_d_stable", dbad, 0);
    tick(1);
    chk("w9_shadow", shadow_q, 4'h9);

    // Simultaneous requests after reset: 0 first, then 1.
    do_reset();
`ifdef LATCH_BANK_CTRL_LOCK_EN
    send_key(8'hA5);
`endif
    push_ack(0, 4'h3);
    push_ack(1, 4'hC);
    fork
      begin
        int l0, e0;
        bit b0;
        wr(0, 4'h3, 1'b0, l0, e0, b0);
        chk("rr_first_lat", l0, LAT);
      end
      begin
        int l1, e1;
        bit b1;
        wr(1, 4'hC, 1'b0, l1, e1, b1);
        chk("rr_second_lat", l1, 2 * LAT + 1);
      end
    join
    wait_drain("rr_drain");

    // Dropping req mid-transaction still completes with ack.
    push_ack(0, 4'h6);
    wdata0 = 4'h6;
    req = 2'b01;
    tick(2);
    req = 2'b00;
    wait_drain("drop_drain");

    // Reset in the middle of the strobe.
    wdata0 = 4'h7;
    req = 2'b01;
    cnt = 0;
    while (!lat_le && cnt < 20) begin
      tick(1);
      cnt++;
    end
    chk("strobe_seen", lat_le, 1);
    rst = 1'b1;
    req = 2'b00;
    tick(1);
    chk("rst_strobe_le", lat_le, 0);
    rst = 1'b0;
    tick(6);
    chk("rst_strobe_shadow", shadow_q, 0);

`ifdef LATCH_BANK_CTRL_LOCK_EN
    // Three wrong keys lock the block for good.
    send_key(8'h00);
    chk("fail1_lockout", lockout, 0);
    send_key(8'h00);
    chk("fail2_lockout", lockout, 0);
    send_key(8'h00);
    chk("fail3_lockout", lockout, 1);
    send_key(8'h00);
    send_key(8'hA5);
    chk("lockout_unlocked", unlocked, 0);
    chk("lockout_sticky", lockout, 1);
    push_err(2'b01);
    req = 2'b01;
    tick(1);
    req = 2'b00;
    tick(2);
`else
    // Keys are ignored; writes work without unlocking.
    send_key(8'h12);
    chk("nolock_unlocked", unlocked, 1);
    chk("nolock_lockout", lockout, 0);
    wr(1, 4'hE, 1'b1, lat, le, dbad);
    chk("nolock_lat", lat, LAT);
    tick(2);
    chk("nolock_err_seen", err_seen, 0);
`endif

    wait_drain("final_drain");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
